// File: rtl/sc_statemachine_carcontrol.sv
// sc_statemachine_carcontrol: turns raw car buttons and crash flag into lane-register clear/load/shift commands
module sc_statemachine_carcontrol #(
  parameter int REPEAT_CYCLES = 25000000,
  parameter int CNT_WIDTH = 25
) (
  input  logic       SC_CARCTRL_CLOCK_50,
  input  logic       SC_CARCTRL_RESET_InLow,
  input  logic       SC_CARCTRL_left_InLow,
  input  logic       SC_CARCTRL_right_InLow,
  input  logic       SC_CARCTRL_start_InLow,
  input  logic       SC_CARCTRL_crash_InLow,
  output logic       SC_CARCTRL_clear_OutLow,
  output logic       SC_CARCTRL_load_OutLow,
  output logic [1:0] SC_CARCTRL_shift_OutBus
);
  typedef enum logic [2:0] {CLEAR, WAIT_START, LOAD, IDLE, SHIFT, HOLD} state_t;
  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(REPEAT_CYCLES - 1);
  state_t state, nxt;
  logic [2:0] sync1, sync2;
  logic start_prev, start_press, crash;
  logic [1:0] dir_req, dir_q;
  logic [CNT_WIDTH-1:0] cnt;
  assign crash = ~SC_CARCTRL_crash_InLow;
  assign start_press = ~sync2[2] & start_prev;
  assign dir_req = sync2[1:0] == 2'b10 ? 2'b01 : sync2[1:0] == 2'b01 ? 2'b10 : 2'b00;
  // two-flop synchronisers for {start,right,left}, plus last start level for edge detection
  always_ff @(posedge SC_CARCTRL_CLOCK_50 or negedge SC_CARCTRL_RESET_InLow)
    if (!SC_CARCTRL_RESET_InLow) begin
      sync1 <= '1;
      sync2 <= '1;
      start_prev <= 1'b1;
    end else begin
      sync1 <= {SC_CARCTRL_start_InLow, SC_CARCTRL_right_InLow, SC_CARCTRL_left_InLow};
      sync2 <= sync1;
      start_prev <= sync2[2];
    end
  // next-state decision; crash outranks direction, release outranks repeat
  always_comb begin
    nxt = state;
    case (state)
      CLEAR:      nxt = WAIT_START;
      WAIT_START: nxt = start_press ? LOAD : WAIT_START;
      LOAD:       nxt = IDLE;
      IDLE:       nxt = crash ? LOAD : dir_req != 2'b00 ? SHIFT : IDLE;
      SHIFT:      nxt = HOLD;
      HOLD:       nxt = crash ? LOAD : dir_req != dir_q ? IDLE : cnt == TERM ? SHIFT : HOLD;
      default:    nxt = CLEAR;
    endcase
  end
  // state, repeat counter, latched direction and outputs registered from the next state
  always_ff @(posedge SC_CARCTRL_CLOCK_50 or negedge SC_CARCTRL_RESET_InLow)
    if (!SC_CARCTRL_RESET_InLow) begin
      state <= CLEAR;
      cnt <= '0;
      dir_q <= 2'b00;
      SC_CARCTRL_clear_OutLow <= 1'b0;
      SC_CARCTRL_load_OutLow <= 1'b1;
      SC_CARCTRL_shift_OutBus <= 2'b00;
    end else begin
      state <= nxt;
      cnt <= state == SHIFT ? '0 : state == HOLD ? cnt + 1'b1 : cnt;
      dir_q <= state == IDLE && nxt == SHIFT ? dir_req : dir_q;
      SC_CARCTRL_clear_OutLow <= nxt != CLEAR;
      SC_CARCTRL_load_OutLow <= nxt != LOAD;
      SC_CARCTRL_shift_OutBus <= nxt != SHIFT ? 2'b00 : state == IDLE ? dir_req : dir_q;
    end
endmodule
